// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Loads a program image into the instruction memory at run time. Bytes arrive
// on a valid/ready stream and are packed big-endian (first byte -> [31:24])
// into 32-bit words. Each completed word is written through the memory's
// write port in a single one-cycle write. busy freezes the pipeline while a
// load runs, and done pulses when the last word has been written.
//
// FSM states:
//   S_IDLE     | waiting for start; capacity check on word_count
//   S_ASSEMBLE | byte_ready=1, collecting four bytes of the current word
//   S_WRITE    | one-cycle mem_we for the assembled word
//   S_DONE     | one-cycle done pulse, back to S_IDLE
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, word_count   load request (IDLE only) and number of words to load
//   byte_in, byte_valid stream input
//   byte_ready          stream accept (S_ASSEMBLE only)
//   mem_we, mem_addr,   instruction memory write port; mem_addr is the byte
//   mem_wdata           address {word_idx, 2'b00}, zero-extended to 32 bits
//   busy, done, error   pipeline hold, completion pulse, sticky overflow flag
// ---------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_WORD  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int                    CAP_INT = (1 << ADDR_WIDTH) - BASE_WORD;
    localparam logic [ADDR_WIDTH:0]   CAP     = CAP_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] BASE    = BASE_WORD[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam int                    PAD     = 30 - ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSEMBLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state;
    logic [1:0]            byte_cnt;
    logic [23:0]           shreg;       // first three bytes of the current word
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  hs;

    assign hs = byte_valid & byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            shreg      <= '0;
            word_idx   <= '0;
            remaining  <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            error <= 1'b0;
                        end else if (word_count <= CAP) begin
                            state      <= S_ASSEMBLE;
                            remaining  <= word_count;
                            word_idx   <= BASE;
                            byte_cnt   <= '0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                S_ASSEMBLE: begin
                    if (hs) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shreg    <= {shreg[15:0], byte_in};
                        if (byte_cnt == 2'd3) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_addr   <= {{PAD{1'b0}}, word_idx, 2'b00};
                            mem_wdata  <= {shreg, byte_in};
                        end
                    end
                end

                S_WRITE: begin
                    mem_we    <= 1'b0;
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Advance only when another word follows, so a load
                        // ending at the top word never wraps the index.
                        word_idx   <= word_idx + IDX_ONE;
                        state      <= S_ASSEMBLE;
                        byte_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        r0, we0, busy0, done0, err0;
    logic [31:0] addr0, wd0;
    logic        r1, we1, busy1, done1, err1;
    logic [31:0] addr1, wd1;

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_WIDTH(10), .BASE_WORD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(r0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .busy(busy0), .done(done0), .error(err0));

    inst_mem_loader #(.ADDR_WIDTH(10), .BASE_WORD(1022)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(r1),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .busy(busy1), .done(done1), .error(err1));

    int n_vec  = 0;
    int n_fail = 0;
    int sel    = 0;
    int cyc    = 0;

    logic [31:0] wa0[$], wdq0[$], wa1[$], wdq1[$];
    int          wc0[$], dc0[$], bf0[$], wc1[$], dc1[$], bf1[$];
    logic        pb0 = 1'b0, pb1 = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (we0) begin wa0.push_back(addr0); wdq0.push_back(wd0); wc0.push_back(cyc); end
        if (we1) begin wa1.push_back(addr1); wdq1.push_back(wd1); wc1.push_back(cyc); end
        if (done0) dc0.push_back(cyc);
        if (done1) dc1.push_back(cyc);
        if (pb0 && !busy0) bf0.push_back(cyc);
        if (pb1 && !busy1) bf1.push_back(cyc);
        pb0 = busy0;
        pb1 = busy1;
    end

    typedef struct {
        int          sel;
        int          nw;
        int          gap;
        logic [31:0] w0, w1;
        logic [31:0] a0, a1;
    } vec_t;

    vec_t vt[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wa0.delete(); wdq0.delete(); wc0.delete(); dc0.delete(); bf0.delete();
        wa1.delete(); wdq1.delete(); wc1.delete(); dc1.delete(); bf1.delete();
    endtask

    task automatic do_start(input int cnt);
        start      = 1'b1;
        word_count = 11'(cnt);
        tick();
        start = 1'b0;
    endtask

    function automatic logic rdy();
        return (sel == 1) ? r1 : r0;
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (!rdy() && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_fail++;
            $display("FAIL ready_timeout: byte %h never accepted", b);
        end
        tick();
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send(w[31-8*k -: 8], gap);
    endtask

    task automatic wait_done();
        int t = 0;
        while (((sel == 1) ? dc1.size() : dc0.size()) == 0 && t < 80) begin
            tick();
            t++;
        end
        if (t >= 80) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", t);
        end
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] qa[$], qd[$];
        int          qc[$], qdn[$], qbf[$];
        logic        e;

        vt[0] = '{sel: 0, nw: 2, gap: 0, w0: 32'h20010028, w1: 32'h20050000,
                  a0: 32'h0, a1: 32'h4};
        vt[1] = '{sel: 0, nw: 2, gap: 3, w0: 32'h20010028, w1: 32'h20050000,
                  a0: 32'h0, a1: 32'h4};
        vt[2] = '{sel: 1, nw: 2, gap: 0, w0: 32'hDEADBEEF, w1: 32'h01234567,
                  a0: 32'hFF8, a1: 32'hFFC};

        rst_n = 1'b0; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(r0), 0);
        chk("rst_we", 32'(we0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_error", 32'(err0), 0);
        chk("rst_addr", addr0, 0);
        chk("rst_wdata", wd0, 0);
        rst_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 3; i++) begin
            sel = vt[i].sel;
            clear_q();
            do_start(vt[i].nw);
            send_word(vt[i].w0, vt[i].gap);
            if (vt[i].nw > 1) send_word(vt[i].w1, vt[i].gap);
            byte_valid = 1'b0;
            wait_done();
            if (sel == 1) begin qa = wa1; qd = wdq1; qc = wc1; qdn = dc1; qbf = bf1; e = err1; end
            else          begin qa = wa0; qd = wdq0; qc = wc0; qdn = dc0; qbf = bf0; e = err0; end
            chk($sformatf("v%0d_nwrites", i), qa.size(), vt[i].nw);
            chk($sformatf("v%0d_ndone", i), qdn.size(), 1);
            chk($sformatf("v%0d_error", i), 32'(e), 0);
            if (qa.size() == vt[i].nw && qdn.size() == 1) begin
                chk($sformatf("v%0d_addr0", i), qa[0], vt[i].a0);
                chk($sformatf("v%0d_data0", i), qd[0], vt[i].w0);
                chk($sformatf("v%0d_done_after_write", i), qdn[0], qc[vt[i].nw-1] + 1);
                chk($sformatf("v%0d_nbusyfall", i), qbf.size(), 1);
                if (qbf.size() == 1) chk($sformatf("v%0d_busy_fall", i), qbf[0], qdn[0]);
                if (vt[i].nw > 1) begin
                    chk($sformatf("v%0d_addr1", i), qa[1], vt[i].a1);
                    chk($sformatf("v%0d_data1", i), qd[1], vt[i].w1);
                    if (vt[i].gap == 0) chk($sformatf("v%0d_period", i), qc[1] - qc[0], 5);
                end
            end
        end

        // zero-length load, overflow, then recovery
        sel = 0;
        clear_q();
        do_start(0);
        chk("zero_done", 32'(done0), 1);
        chk("zero_busy", 32'(busy0), 0);
        tick();
        chk("zero_done_pulse", 32'(done0), 0);
        do_start(1025);
        chk("ovf_error", 32'(err0), 1);
        chk("ovf_busy", 32'(busy0), 0);
        chk("ovf_ready", 32'(r0), 0);
        repeat (5) tick();
        chk("ovf_error_sticky", 32'(err0), 1);
        chk("zero_ovf_writes", wa0.size(), 0);
        clear_q();
        do_start(1);
        chk("recover_error", 32'(err0), 0);
        chk("recover_busy", 32'(busy0), 1);
        send_word(32'h01020304, 0);
        byte_valid = 1'b0;
        wait_done();
        chk("recover_nwrites", wa0.size(), 1);
        if (wdq0.size() == 1) chk("recover_data", wdq0[0], 32'h01020304);

        // start during ASSEMBLE is ignored
        clear_q();
        do_start(1);
        send(8'h11, 0);
        send(8'h22, 0);
        byte_valid = 1'b0;
        do_start(2);
        send(8'h33, 0);
        send(8'h44, 0);
        byte_valid = 1'b0;
        wait_done();
        repeat (10) tick();
        chk("midstart_nwrites", wa0.size(), 1);
        if (wa0.size() == 1) begin
            chk("midstart_data", wdq0[0], 32'h11223344);
            chk("midstart_addr", wa0[0], 32'h0);
        end
        chk("midstart_idle_ready", 32'(r0), 0);
        chk("midstart_idle_busy", 32'(busy0), 0);

        // async reset mid-load after 6 of 8 bytes
        clear_q();
        do_start(2);
        send_word(32'hCAFEF00D, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(r0), 0);
        chk("arst_busy", 32'(busy0), 0);
        chk("arst_we", 32'(we0), 0);
        chk("arst_addr", addr0, 0);
        chk("arst_wdata", wd0, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("arst_nwrites", wa0.size(), 1);
        chk("arst_ndone", dc0.size(), 0);

        clear_q();
        do_start(1);
        send_word(32'hAC0507D0, 0);
        byte_valid = 1'b0;
        wait_done();
        chk("post_rst_nwrites", wa0.size(), 1);
        if (wa0.size() == 1) begin
            chk("post_rst_addr", wa0[0], 32'h0);
            chk("post_rst_data", wdq0[0], 32'hAC0507D0);
        end

        // BASE_WORD=1022: three words exceed capacity
        sel = 1;
        clear_q();
        do_start(3);
        chk("base_ovf_error", 32'(err1), 1);
        chk("base_ovf_busy", 32'(busy1), 0);
        repeat (5) tick();
        chk("base_ovf_nwrites", wa1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Write-side counterpart to the instruction memory. Accepts a program image as a byte stream over a valid/ready handshake, packs the bytes big-endian into 32-bit instruction words, and issues one word-aligned write per word into the instruction memory's write port. It holds the pipeline frozen while loading and signals completion, so programs are loaded at run time rather than fixed in an initial block.

Parameters:
ADDR_WIDTH, 10, word-address width of the instruction memory (1024 words)
BASE_WORD, 0, word index that receives the first loaded instruction

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
word_count  input  ADDR_WIDTH+1  number of words to load; latched on accepted start
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable, one cycle per word
mem_addr  output  32  byte address of write, {word_idx, 2'b00}, zero-extended
mem_wdata  output  32  assembled instruction word
busy  output  1  load in progress; drives pipeline hold
done  output  1  one-cycle pulse at successful end of load
error  output  1  sticky; set when word_count exceeds capacity, cleared by next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE. byte_ready, mem_we, busy, done and error are 0. mem_addr, mem_wdata, the byte counter, the word index and the remaining count are 0. Takes effect immediately and also mid-load. The partial word is discarded. No write is issued after reset deasserts.
- State machine:
  - IDLE to ASSEMBLE on start=1 with 0 < word_count <= 2^ADDR_WIDTH - BASE_WORD. Latch remaining=word_count, word_idx=BASE_WORD, byte_cnt=0, error=0, busy=1.
  - IDLE to DONE on start=1 with word_count=0. No writes.
  - IDLE stays IDLE on start=1 with word_count > 2^ADDR_WIDTH - BASE_WORD. Set error=1, no writes, busy stays 0.
  - ASSEMBLE: byte_ready=1. A handshake occurs when byte_valid & byte_ready. On a handshake, shift the byte in MSB-first (first byte goes to bits 31:24, fourth byte to 7:0) and increment byte_cnt (2 bits). On the 4th handshake, go to WRITE.
  - WRITE (exactly one cycle): byte_ready=0, mem_we=1, mem_addr={word_idx,2'b00}, mem_wdata=assembled word. Next cycle: word_idx+1, remaining-1. If the new remaining is 0, go to DONE; otherwise go to ASSEMBLE.
  - DONE (one cycle): done=1, busy=0, then go to IDLE.
- Latency: mem_we asserts in the cycle after the 4th byte handshake. The minimum period is 5 cycles per word.
- byte_valid low in ASSEMBLE: wait indefinitely with no timeout. Partial bytes are retained.
- start in any state other than IDLE is ignored. Bytes presented in IDLE, WRITE or DONE are not accepted (byte_ready=0).
- mem_we is never high outside WRITE. mem_addr and mem_wdata hold their last values when mem_we=0.
- word_idx never wraps. The capacity check guarantees the final index is at most 2^ADDR_WIDTH-1.
- busy=1 in ASSEMBLE and WRITE only.

Test Plan:
- Load 2 words with BASE_WORD=0, bytes 20 01 00 28 20 05 00 00, valid held high -> first write has mem_addr=0x0, mem_wdata=0x20010028; second write has mem_addr=0x4, mem_wdata=0x20050000; writes occur 5 cycles apart; done pulses one cycle after the 2nd write; busy falls with done.
- Backpressure: same 2 words with byte_valid low for 3 cycles between every byte -> identical write data and addresses, exactly two mem_we pulses, no byte lost or duplicated.
- start with word_count=0 -> done pulses on the next cycle, no mem_we, busy stays 0. Then start with word_count=1025 (ADDR_WIDTH=10) -> error=1, no writes, stays IDLE. Then a valid start -> error clears.
- start pulsed while in ASSEMBLE after 2 bytes of a 1-word load -> ignored; the word completes with correct data; exactly one write occurs.
- rst_n low after 6 of 8 bytes of a 2-word load -> outputs reset asynchronously; no second write. A new 1-word load of AC 05 07 D0 -> mem_addr=0x0, mem_wdata=0xAC0507D0.
- BASE_WORD=1022, load 2 words -> writes at 0xFF8 and 0xFFC. word_count=3 -> error=1, no writes.
